// File: rtl/spell_mem_pkg.sv
// spell_mem_pkg
// Shared types and constants for the SPELL internal memory.
//   state_t   : access FSM states
//   CODE_FILL : value every code byte reads after reset
//   DATA_FILL : value every data byte reads after reset
//   LAT_W     : width of the access latency counter
package spell_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CODE_FILL = 8'hFF;
  localparam logic [7:0] DATA_FILL = 8'h00;
  localparam int         LAT_W     = 4;

endpackage

// File: rtl/spell_mem_array.sv
// spell_mem_array
// Byte-wide storage with asynchronous clear and combinational read.
// With INVERT=1 the bytes are stored complemented, so cleared storage
// reads back as 8'hFF.
//   clk, rst_n : clock, async active-low clear of all bytes
//   we         : write enable for addr
//   addr       : byte address (addresses >= SIZE are never written)
//   wdata      : write data
//   rdata      : read data at addr (fill value when addr >= SIZE)
module spell_mem_array
  import spell_mem_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit INVERT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [SIZE];

  // Decode by compare rather than by indexing so addresses beyond SIZE
  // never alias onto a stored byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= 8'h00;
    end else if (we) begin
      for (int i = 0; i < SIZE; i++) begin
        if (addr == ADDR_WIDTH'(i)) mem[i] <= INVERT ? ~wdata : wdata;
      end
    end
  end

  always_comb begin
    rdata = INVERT ? CODE_FILL : DATA_FILL;
    for (int i = 0; i < SIZE; i++) begin
      if (addr == ADDR_WIDTH'(i)) rdata = INVERT ? ~mem[i] : mem[i];
    end
  end

endmodule

// File: rtl/spell_mem_param.sv
// spell_mem_param
// SPELL internal memory: separate code and data spaces behind a single
// select/data_ready handshake, with configurable latency, abort on
// deselect, code write-protect and an error flag.
//   clk, rst_n       : clock, async active-low reset
//   select           : access request, held until data_ready
//   addr             : byte address in the selected space
//   data_in          : write data
//   memory_type_data : 1 = data space, 0 = code space
//   write            : 1 = write, 0 = read
//   code_wp          : code-space write protect
//   data_out         : read data (holds across writes and idle)
//   data_ready       : access complete
//   error            : completed access out of range or write-protected
//
// state | meaning
// IDLE  | waiting for select; operands latched on the accepting edge
// WAIT  | latency countdown; deselect aborts with no side effects
// DONE  | access committed; data_ready high until select drops
module spell_mem_param
  import spell_mem_pkg::*;
#(
  parameter int CODE_SIZE  = 32,
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  select,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_in,
  input  logic                  memory_type_data,
  input  logic                  write,
  input  logic                  code_wp,
  output logic [7:0]            data_out,
  output logic                  data_ready,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] CODE_LIM = (ADDR_WIDTH + 1)'(CODE_SIZE);
  localparam logic [ADDR_WIDTH:0] DATA_LIM = (ADDR_WIDTH + 1)'(DATA_SIZE);

  state_t state, state_nxt;
  logic [LAT_W-1:0] counter;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [7:0]            lat_wdata;
  logic                  lat_dspace, lat_write, lat_wp;

  // With zero latency the accepting edge is also the commit edge, so the
  // live inputs stand in for the latch while in IDLE.
  logic                  in_idle;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [7:0]            op_wdata;
  logic                  op_dspace, op_write, op_wp;
  logic                  commit, in_range, blocked;
  logic                  code_we, data_we;
  logic [7:0]            code_rdata, data_rdata;

  assign in_idle   = (state == IDLE);
  assign op_addr   = in_idle ? addr             : lat_addr;
  assign op_wdata  = in_idle ? data_in          : lat_wdata;
  assign op_dspace = in_idle ? memory_type_data : lat_dspace;
  assign op_write  = in_idle ? write            : lat_write;
  assign op_wp     = in_idle ? code_wp          : lat_wp;

  assign commit = select &&
                  ((in_idle && (LATENCY == 0)) ||
                   ((state == WAIT) && (counter == LAT_W'(1))));

  assign in_range = op_dspace ? ({1'b0, op_addr} < DATA_LIM)
                              : ({1'b0, op_addr} < CODE_LIM);
  assign blocked  = !op_dspace && op_write && op_wp;

  assign code_we = commit && op_write && !op_dspace && in_range && !op_wp;
  assign data_we = commit && op_write &&  op_dspace && in_range;

  spell_mem_array #(.SIZE(CODE_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .INVERT(1'b1)) u_code (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (code_we),
    .addr  (op_addr),
    .wdata (op_wdata),
    .rdata (code_rdata)
  );

  spell_mem_array #(.SIZE(DATA_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .INVERT(1'b0)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (data_we),
    .addr  (op_addr),
    .wdata (op_wdata),
    .rdata (data_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (select) state_nxt = (LATENCY == 0) ? DONE : WAIT;
      WAIT: begin
        if (!select)                    state_nxt = IDLE;
        else if (counter == LAT_W'(1))  state_nxt = DONE;
      end
      DONE: if (!select) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= 8'h00;
      lat_dspace <= 1'b0;
      lat_write  <= 1'b0;
      lat_wp     <= 1'b0;
    end else if (in_idle && select) begin
      counter    <= LAT_W'(LATENCY);
      lat_addr   <= addr;
      lat_wdata  <= data_in;
      lat_dspace <= memory_type_data;
      lat_write  <= write;
      lat_wp     <= code_wp;
    end else if (state == WAIT) begin
      counter <= counter - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      error    <= 1'b0;
    end else if (commit) begin
      error <= !in_range || blocked;
      if (!op_write) begin
        if (!in_range)      data_out <= op_dspace ? DATA_FILL : CODE_FILL;
        else if (op_dspace) data_out <= data_rdata;
        else                data_out <= code_rdata;
      end
    end else if ((state == DONE) && !select) begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spell_mem_param.sv
module tb_spell_mem_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       select = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       memory_type_data = 1'b0;
  logic       write = 1'b0;
  logic       code_wp = 1'b0;

  logic [7:0] dout [2];
  logic [1:0] rdy;
  logic [1:0] err;

  always #5 clk = ~clk;

  spell_mem_param #(.CODE_SIZE(32), .DATA_SIZE(8), .ADDR_WIDTH(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .select(select), .addr(addr), .data_in(data_in),
    .memory_type_data(memory_type_data), .write(write), .code_wp(code_wp),
    .data_out(dout[0]), .data_ready(rdy[0]), .error(err[0])
  );

  spell_mem_param #(.CODE_SIZE(32), .DATA_SIZE(8), .ADDR_WIDTH(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .select(select), .addr(addr), .data_in(data_in),
    .memory_type_data(memory_type_data), .write(write), .code_wp(code_wp),
    .data_out(dout[1]), .data_ready(rdy[1]), .error(err[1])
  );

  // Reference model: one plain memory image per instance.
  int         lat [2] = '{0, 3};
  logic [7:0] code_m [2][32];
  logic [7:0] data_m [2][8];
  logic [7:0] dout_m [2];
  logic       err_m  [2];

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) code_m[k][i] = 8'hFF;
      for (int i = 0; i < 8; i++)  data_m[k][i] = 8'h00;
      dout_m[k] = 8'h00;
      err_m[k]  = 1'b0;
    end
  endfunction

  function automatic void model_commit(int k, bit dsp, bit wr, logic [7:0] a, logic [7:0] d, bit wp);
    int ia;
    bit inr;
    ia  = int'(a);
    inr = dsp ? (ia < 8) : (ia < 32);
    err_m[k] = !inr || (!dsp && wr && wp);
    if (wr) begin
      if (!err_m[k]) begin
        if (dsp) data_m[k][ia] = d;
        else     code_m[k][ia] = d;
      end
    end else begin
      if (!inr)     dout_m[k] = dsp ? 8'h00 : 8'hFF;
      else if (dsp) dout_m[k] = data_m[k][ia];
      else          dout_m[k] = code_m[k][ia];
    end
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lat%0d obs=%h exp=%h", tag, lat[k], obs, exp);
    end
  endtask

  // e = number of select-high edges seen so far in the current access
  // (0 when idle); data_ready is expected once e reaches latency+1.
  task automatic check_all(input string tag, input int e);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rdy"},  k, {7'b0, rdy[k]}, {7'b0, (e >= lat[k] + 1)});
      chk({tag, "_err"},  k, {7'b0, err[k]}, {7'b0, err_m[k]});
      chk({tag, "_dout"}, k, dout[k], dout_m[k]);
    end
  endtask

  task automatic access(input bit dsp, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input bit wp, input int hold);
    @(negedge clk);
    memory_type_data = dsp;
    write            = wr;
    addr             = a;
    data_in          = d;
    code_wp          = wp;
    select           = 1'b1;
    for (int e = 1; e <= hold; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        if (e == lat[k] + 1) model_commit(k, dsp, wr, a, d, wp);
      check_all("acc", e);
      // operands are latched; later input changes must have no effect
      if (e == 1) begin
        addr             = 8'($urandom);
        data_in          = 8'($urandom);
        write            = 1'($urandom);
        memory_type_data = 1'($urandom);
        code_wp          = 1'($urandom);
      end
    end
    @(negedge clk);
    select = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) err_m[k] = 1'b0;
    check_all("idle", 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b0, 8'd5,  8'h00, 1'b0, 4);   // code[5] -> FF
    access(1'b1, 1'b0, 8'd3,  8'h00, 1'b0, 4);   // data[3] -> 00
    access(1'b1, 1'b1, 8'd2,  8'hA5, 1'b0, 4);   // data[2] = A5
    access(1'b1, 1'b0, 8'd2,  8'h00, 1'b0, 4);   // read back A5
    access(1'b0, 1'b1, 8'd7,  8'h12, 1'b0, 2);   // aborts on latency 3
    access(1'b0, 1'b0, 8'd7,  8'h00, 1'b0, 4);
    access(1'b0, 1'b0, 8'd32, 8'h00, 1'b0, 4);   // out of range code read
    access(1'b1, 1'b1, 8'd8,  8'h55, 1'b0, 4);   // out of range data write
    access(1'b1, 1'b0, 8'd0,  8'h00, 1'b0, 4);
    access(1'b0, 1'b1, 8'd1,  8'h3C, 1'b1, 4);   // write-protected
    access(1'b0, 1'b0, 8'd1,  8'h00, 1'b0, 4);
    access(1'b0, 1'b1, 8'd1,  8'h3C, 1'b0, 4);
    access(1'b0, 1'b0, 8'd1,  8'h00, 1'b0, 4);
    access(1'b1, 1'b1, 8'd7,  8'h99, 1'b1, 4);   // data writes ignore code_wp
    access(1'b1, 1'b0, 8'd7,  8'h00, 1'b0, 4);

    // async reset between edges while the latency-3 instance is in WAIT
    @(negedge clk);
    memory_type_data = 1'b1;
    write            = 1'b1;
    addr             = 8'd5;
    data_in          = 8'h77;
    select           = 1'b1;
    @(posedge clk);
    #1;
    chk("midwait_rdy", 1, {7'b0, rdy[1]}, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst", 0);
    select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 8'd1, 8'h00, 1'b0, 4);    // earlier 3C is gone
    access(1'b1, 1'b0, 8'd2, 8'h00, 1'b0, 4);    // earlier A5 is gone
    access(1'b1, 1'b0, 8'd5, 8'h00, 1'b0, 4);

    for (int n = 0; n < 80; n++) begin
      bit         r_dsp, r_wr, r_wp;
      logic [7:0] r_a;
      int         r_hold;
      r_dsp  = 1'($urandom);
      r_wr   = 1'($urandom);
      r_wp   = ($urandom_range(0, 2) == 0);
      r_a    = r_dsp ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 35));
      r_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 6);
      access(r_dsp, r_wr, r_a, 8'($urandom), r_wp, r_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
